// File: rtl/sr_latch_driver.sv
// sr_latch_driver: sequences writes into an external bank of WIDTH SR latches.
//
// A write is accepted in IDLE. The driver then pulses Reset on the bits that
// must end up 0 (CLEAR) and pulses Set on the bits that must end up 1 (SET).
// Splitting the write over two cycles means Set and Reset are never both high
// on the same bit. After reset release, one INIT cycle clears the whole bank.
//
// Build option: define SR_LATCH_DRIVER_VERIFY_EN to add a VERIFY cycle that
// compares the latch outputs Q against the written word and updates Mismatch.
// Without it, Q is ignored, Mismatch is tied low and Done pulses during SET.
//
// Ports:
//   Clk       in   sole clock, rising edge
//   Rst       in   synchronous active-high reset
//   WrValid   in   write request valid
//   WrData    in   [WIDTH] word to store
//   WrReady   out  driver can accept a write (high in IDLE only)
//   Set       out  [WIDTH] per-bit set command
//   Reset     out  [WIDTH] per-bit reset command
//   En        out  latch bank enable
//   Q         in   [WIDTH] latch outputs, read back in VERIFY
//   Done      out  one-cycle pulse when a write completes
//   Mismatch  out  last verified write read back wrong
//
// All outputs come straight from flops: each one is decoded from the state
// being entered and registered on the same edge as the state.

module sr_latch_driver #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             WrValid,
    input  logic [WIDTH-1:0] WrData,
    output logic             WrReady,
    output logic [WIDTH-1:0] Set,
    output logic [WIDTH-1:0] Reset,
    output logic             En,
    input  logic [WIDTH-1:0] Q,
    output logic             Done,
    output logic             Mismatch
);

    localparam logic [2:0] st_init   = 3'd0;
    localparam logic [2:0] st_idle   = 3'd1;
    localparam logic [2:0] st_clear  = 3'd2;
    localparam logic [2:0] st_set    = 3'd3;
`ifdef SR_LATCH_DRIVER_VERIFY_EN
    localparam logic [2:0] st_verify = 3'd4;
`endif

    logic [2:0]       state_q, state_d;
    logic             hold_q;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] set_q, set_d;
    logic [WIDTH-1:0] reset_q, reset_d;
    logic             en_q, en_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;

    // Next state. hold_q marks "just left reset": INIT is parked for one more
    // edge so that the first cycle after release shows the INIT outputs while
    // the cycles spent in reset show all-zero outputs.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            st_init:  state_d = hold_q ? st_init : st_idle;
            st_idle: begin
                if (WrValid && ready_q) begin
                    data_d  = WrData;
                    state_d = st_clear;
                end
            end
            st_clear: state_d = st_set;
`ifdef SR_LATCH_DRIVER_VERIFY_EN
            st_set:    state_d = st_verify;
            st_verify: state_d = st_idle;
`else
            st_set:    state_d = st_idle;
`endif
            default:  state_d = st_init;
        endcase
    end

    // Output decode of the state being entered; uses data_d so CLEAR already
    // sees the word captured on the accepting edge.
    always_comb begin
        set_d   = '0;
        reset_d = '0;
        en_d    = 1'b0;
        ready_d = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            st_init: begin
                reset_d = '1;
                en_d    = 1'b1;
            end
            st_idle:  ready_d = 1'b1;
            st_clear: begin
                reset_d = ~data_d;
                en_d    = 1'b1;
            end
            st_set: begin
                set_d = data_d;
                en_d  = 1'b1;
`ifndef SR_LATCH_DRIVER_VERIFY_EN
                done_d = 1'b1;
`endif
            end
`ifdef SR_LATCH_DRIVER_VERIFY_EN
            st_verify: done_d = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= st_init;
            hold_q  <= 1'b1;
            data_q  <= '0;
            set_q   <= '0;
            reset_q <= '0;
            en_q    <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= 1'b0;
            data_q  <= data_d;
            set_q   <= set_d;
            reset_q <= reset_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

`ifdef SR_LATCH_DRIVER_VERIFY_EN
    logic mismatch_q, mismatch_d;

    // Q has settled by the end of VERIFY; the flag then holds until the next
    // VERIFY, surviving later accepts.
    always_comb begin
        mismatch_d = mismatch_q;
        if (state_q == st_verify) begin
            mismatch_d = (Q != data_q);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign Mismatch = mismatch_q;
`else
    logic unused_q;
    assign unused_q = ^Q;
    assign Mismatch = 1'b0;
`endif

    assign WrReady = ready_q;
    assign Set     = set_q;
    assign Reset   = reset_q;
    assign En      = en_q;
    assign Done    = done_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: directed write scenarios followed by random
// traffic with occasional resets. An ideal SR latch bank (with an optional
// stuck-at-0 mask) sits on the driver outputs; a transaction-level model
// counts cycles since reset release / since accept to predict every output.
// Follows SR_LATCH_DRIVER_VERIFY_EN the same way the design does.

module tb_sr_latch_driver;

    localparam int W = 4;
`ifdef SR_LATCH_DRIVER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    // Cycles from accept edge to the next possible accept edge.
    localparam int WLEN = VERIFY ? 4 : 3;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         WrValid = 1'b0;
    logic [W-1:0] WrData = '0;
    logic         WrReady;
    logic [W-1:0] Set;
    logic [W-1:0] Reset;
    logic         En;
    logic [W-1:0] Q;
    logic         Done;
    logic         Mismatch;

    sr_latch_driver #(
        .WIDTH(W)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .WrValid (WrValid),
        .WrData  (WrData),
        .WrReady (WrReady),
        .Set     (Set),
        .Reset   (Reset),
        .En      (En),
        .Q       (Q),
        .Done    (Done),
        .Mismatch(Mismatch)
    );

    always #5 Clk = ~Clk;

    // Ideal latch bank, settled mid-cycle; stuck forces bits of Q to 0.
    logic [W-1:0] q_lat = '1;
    logic [W-1:0] stuck = '0;
    always @(negedge Clk) begin
        if (En === 1'b1) q_lat <= (q_lat & ~Reset) | Set;
    end
    assign Q = q_lat & ~stuck;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    bit           m_inrst = 1'b1;  // last edge had Rst
    bit           m_init  = 1'b0;  // in the INIT cycle
    bit           m_busy  = 1'b0;  // a write is in flight
    int           m_since = 0;     // cycles since accept edge
    logic [W-1:0] m_data  = '0;
    bit           m_mis   = 1'b0;
    bit           m_known = 1'b0;  // m_lat is the expected bank content
    logic [W-1:0] m_lat   = '0;
    logic         prev_done = 1'b0;

    task automatic model_step(input logic r, input logic v, input logic [W-1:0] d);
        if (r) begin
            m_inrst = 1'b1; m_init = 1'b0; m_busy = 1'b0; m_since = 0;
            m_data = '0; m_mis = 1'b0; m_known = 1'b0;
        end else if (m_inrst) begin
            m_inrst = 1'b0; m_init = 1'b1;
        end else if (m_init) begin
            m_init = 1'b0; m_lat = '0; m_known = 1'b1;
        end else if (m_busy) begin
            m_since++;
            if (m_since == WLEN) begin
                m_busy = 1'b0; m_lat = m_data; m_known = 1'b1;
                if (VERIFY) m_mis = ((m_data & ~stuck) != m_data);
            end
        end else if (v) begin
            m_busy = 1'b1; m_since = 1; m_data = d; m_known = 1'b0;
        end
    endtask

    task automatic compare_outputs();
        logic         e_ready, e_en, e_done;
        logic [W-1:0] e_set, e_reset;
        e_ready = !m_inrst && !m_init && !m_busy;
        e_en    = m_init || (m_busy && m_since <= 2);
        e_set   = (m_busy && m_since == 2) ? m_data : '0;
        e_reset = m_init ? '1 : ((m_busy && m_since == 1) ? ~m_data : '0);
        e_done  = m_busy && (m_since == (VERIFY ? 3 : 2));
        check_eq("wr_ready", 32'(WrReady), 32'(e_ready));
        check_eq("en", 32'(En), 32'(e_en));
        check_eq("set", 32'(Set), 32'(e_set));
        check_eq("reset", 32'(Reset), 32'(e_reset));
        check_eq("done", 32'(Done), 32'(e_done));
        check_eq("mismatch", 32'(Mismatch), 32'(m_mis));
        check_eq("set_reset_overlap", 32'(Set & Reset), 32'd0);
        check_eq("done_back_to_back", 32'(prev_done & Done), 32'd0);
        if (e_ready && m_known) check_eq("q_content", 32'(Q), 32'(m_lat & ~stuck));
        prev_done = Done;
    endtask

    task automatic tick(input logic r, input logic v, input logic [W-1:0] d);
        Rst = r; WrValid = v; WrData = d;
        @(posedge Clk);
        #1;
        model_step(r, v, d);
        compare_outputs();
    endtask

    task automatic write_word(input logic [W-1:0] d);
        tick(1'b0, 1'b1, d);
        for (int i = 0; i < WLEN; i++) tick(1'b0, 1'b0, ~d);  // ignored while busy
    endtask

    initial begin
        // Reset held, then INIT clears the bank that starts all ones.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, '0);
        check_eq("q_after_init", 32'(Q), 32'd0);

        write_word(4'b0101);
        check_eq("q_0101", 32'(Q), 32'h5);

        // Back-to-back: WrValid held, second accept exactly WLEN cycles later.
        tick(1'b0, 1'b1, 4'b1100);
        for (int i = 0; i < WLEN; i++) tick(1'b0, 1'b1, 4'b0011);
        for (int i = 0; i < WLEN; i++) tick(1'b0, 1'b0, '0);
        check_eq("q_0011", 32'(Q), 32'h3);

        // Bit 0 stuck at 0: mismatch flagged, then cleared by a clean write.
        stuck = 4'b0001;
        write_word(4'b1111);
        check_eq("mismatch_stuck", 32'(Mismatch), 32'(VERIFY));
        write_word(4'b0000);
        check_eq("mismatch_cleared", 32'(Mismatch), 32'd0);
        stuck = '0;
        tick(1'b0, 1'b0, '0);

        // Reset during SET aborts the write; INIT clears the bank.
        tick(1'b0, 1'b1, 4'b1010);
        tick(1'b0, 1'b0, '0);
        tick(1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, '0);
        check_eq("q_after_abort", 32'(Q), 32'd0);

        // Random traffic with sporadic resets and WrData churn.
        for (int i = 0; i < 500; i++) begin
            logic         r, v;
            logic [W-1:0] d;
            r = ($urandom_range(39) == 0);
            v = 1'(($urandom_range(3) != 0));
            d = W'($urandom);
            tick(r, v, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
